// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of an asynchronous test signal over a
// programmable gate window (freq_base clocks), then holds the result on freq
// with freq_en high for max(time_del,1) clocks before the next gate.
// Optional build macro FREQ_AVG_EN: report the truncating mean of the last
// four gate results instead of the single-gate count.
module freq_gate_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] freq_base,
  input  logic [CNT_W-1:0] time_del,
  output logic [CNT_W-1:0] freq,
  output logic             freq_en,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GATE  = 3'd1,
    LOAD  = 3'd2,
    LOAD2 = 3'd3,
    DELAY = 3'd4
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sync;
  logic                 sync_d;
  logic                 edge_pulse;
  logic [CNT_W-1:0]     edge_cnt;
  logic [CNT_W-1:0]     gate_cnt;
  logic [CNT_W-1:0]     del_cnt;
  logic [CNT_W-1:0]     del_len;

`ifdef FREQ_AVG_EN
  logic [CNT_W-1:0]          gate_len;
  logic [3:0][CNT_W-1:0]     hist;
  logic [CNT_W+1:0]          sum;
  logic [2:0]                hcnt;
`endif

  assign edge_pulse = sync[SYNC_STAGES-1] & ~sync_d;

  // Metastability synchronizer followed by a one-flop edge detector.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end

  // Gate/load/delay sequencer; all outputs are registered here.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      edge_cnt <= '0;
      gate_cnt <= '0;
      del_cnt  <= '0;
      del_len  <= '0;
      freq     <= '0;
      freq_en  <= 1'b0;
      busy     <= 1'b0;
`ifdef FREQ_AVG_EN
      gate_len <= '0;
      hist     <= '0;
      sum      <= '0;
      hcnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // parameters are sampled only here, so mid-gate changes wait a gate
          if (freq_base != '0) begin
            gate_cnt <= freq_base;
            del_len  <= time_del;
            edge_cnt <= '0;
            busy     <= 1'b1;
            state    <= GATE;
`ifdef FREQ_AVG_EN
            gate_len <= freq_base;
            // results from a different gate length are not comparable
            if (freq_base != gate_len) begin
              hist <= '0;
              sum  <= '0;
              hcnt <= '0;
            end
`endif
          end
        end
        GATE: begin
          edge_cnt <= edge_cnt + {{(CNT_W-1){1'b0}}, edge_pulse};
          if (gate_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            busy  <= 1'b0;
            state <= LOAD;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end
        LOAD: begin
          // a zero delay still spends one cycle showing the result
          del_cnt <= (del_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : del_len;
`ifdef FREQ_AVG_EN
          hist  <= {hist[2:0], edge_cnt};
          sum   <= sum + {2'b00, edge_cnt} - {2'b00, hist[3]};
          hcnt  <= (hcnt == 3'd4) ? 3'd4 : hcnt + 3'd1;
          state <= LOAD2;
`else
          freq    <= edge_cnt;
          freq_en <= 1'b1;
          state   <= DELAY;
`endif
        end
`ifdef FREQ_AVG_EN
        LOAD2: begin
          freq    <= sum[CNT_W+1:2];
          freq_en <= (hcnt == 3'd4);
          state   <= DELAY;
        end
`endif
        DELAY: begin
          if (del_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            freq_en <= 1'b0;
            state   <= IDLE;
          end else begin
            del_cnt <= del_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
